riscv_crypto_fu_sha_pipe: RTL and testbench

//  Pipelined SHA-256/SHA-512 sigma/sum unit for the crypto FU, replacing the combinational SHA-256-only path.

---
 rtl/riscv_crypto_sha_pkg.sv | 40 ++++
 rtl/riscv_crypto_sha_core.sv | 79 +++++++
 rtl/riscv_crypto_fu_sha_pipe.sv | 109 ++++++++++
 tb/tb_riscv_crypto_fu_sha_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_crypto_sha_pkg.sv
// Shared opcodes, stage payload and rotate helpers for the pipelined SHA sigma/sum unit.
package riscv_crypto_sha_pkg;

  localparam logic [3:0] SHA_OP_NOP      = 4'd0;
  localparam logic [3:0] SHA_OP_S256SIG0 = 4'd1;
  localparam logic [3:0] SHA_OP_S256SIG1 = 4'd2;
  localparam logic [3:0] SHA_OP_S256SUM0 = 4'd3;
  localparam logic [3:0] SHA_OP_S256SUM1 = 4'd4;
  localparam logic [3:0] SHA_OP_S512SIG0 = 4'd5;
  localparam logic [3:0] SHA_OP_S512SIG1 = 4'd6;
  localparam logic [3:0] SHA_OP_S512SUM0 = 4'd7;
  localparam logic [3:0] SHA_OP_S512SUM1 = 4'd8;
  localparam logic [3:0] SHA_OP_SIG0L    = 4'd9;
  localparam logic [3:0] SHA_OP_SIG0H    = 4'd10;
  localparam logic [3:0] SHA_OP_SIG1L    = 4'd11;
  localparam logic [3:0] SHA_OP_SIG1H    = 4'd12;
  localparam logic [3:0] SHA_OP_SUM0R    = 4'd13;
  localparam logic [3:0] SHA_OP_SUM1R    = 4'd14;

  // Operands are held at 64 bits so one payload type serves both XLEN builds.
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  tag;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } sha_payload_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/riscv_crypto_sha_core.sv
// Combinational SHA-256/SHA-512 sigma/sum datapath with illegal-op decode.
module riscv_crypto_sha_core
  import riscv_crypto_sha_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SHA512_EN = 1
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            err
);

  localparam bit RV64   = (XLEN == 64);
  localparam bit HAS512 = (SHA512_EN != 0);

  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] x;
  logic [63:0] res;
  logic        legal;
  logic        unused_bits;

  assign a = rs1[31:0];
  assign b = rs2[31:0];
  assign x = 64'(rs1);

  always_comb begin
    res   = '0;
    legal = 1'b0;
    case (op)
      SHA_OP_S256SIG0: begin res = sext32(ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3));  legal = 1'b1; end
      SHA_OP_S256SIG1: begin res = sext32(ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10)); legal = 1'b1; end
      SHA_OP_S256SUM0: begin res = sext32(ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)); legal = 1'b1; end
      SHA_OP_S256SUM1: begin res = sext32(ror32(a, 6) ^ ror32(a, 11) ^ ror32(a, 25)); legal = 1'b1; end
      SHA_OP_S512SIG0: begin res = ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);     legal = RV64 && HAS512; end
      SHA_OP_S512SIG1: begin res = ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);   legal = RV64 && HAS512; end
      SHA_OP_S512SUM0: begin res = ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39); legal = RV64 && HAS512; end
      SHA_OP_S512SUM1: begin res = ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41); legal = RV64 && HAS512; end
      // RV32 half-word forms: a and b are the two 32-bit halves of a 64-bit word.
      SHA_OP_SIG0L: begin
        res   = {32'h0, (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 25) ^ (b << 24)};
        legal = !RV64 && HAS512;
      end
      SHA_OP_SIG0H: begin
        res   = {32'h0, (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 24)};
        legal = !RV64 && HAS512;
      end
      SHA_OP_SIG1L: begin
        res   = {32'h0, (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 26) ^ (b << 13)};
        legal = !RV64 && HAS512;
      end
      SHA_OP_SIG1H: begin
        res   = {32'h0, (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 13)};
        legal = !RV64 && HAS512;
      end
      SHA_OP_SUM0R: begin
        res   = {32'h0, (a << 25) ^ (a << 30) ^ (a >> 28) ^ (b >> 7) ^ (b >> 2) ^ (b << 4)};
        legal = !RV64 && HAS512;
      end
      SHA_OP_SUM1R: begin
        res   = {32'h0, (a << 23) ^ (a >> 14) ^ (a >> 18) ^ (b >> 9) ^ (b << 18) ^ (b << 14)};
        legal = !RV64 && HAS512;
      end
      default: begin
        res   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign rd  = legal ? res[XLEN-1:0] : '0;
  assign err = !legal;

  // Upper result bits (XLEN=32) and rs2 (XLEN=64) are structurally dead.
  assign unused_bits = ^{res, rs2};

endmodule

// File: rtl/riscv_crypto_fu_sha_pipe.sv
// Pipelined SHA sigma/sum unit: optional input register, shared core, output register.
module riscv_crypto_fu_sha_pipe
  import riscv_crypto_sha_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int SHA512_EN   = 1
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_tag,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd,
  output logic [4:0]      out_tag,
  output logic            out_err
);

  // Handshake: a transfer happens on a side when valid & ready are both high at
  // the clock edge. A stage accepts new data when it is empty or when its own
  // contents move downstream in the same cycle; otherwise it holds unchanged.

  sha_payload_t    in_p;
  sha_payload_t    core_p;
  logic            core_v;
  logic [XLEN-1:0] core_rd;
  logic            core_err;
  logic            out_adv;
  logic            unused_hi;

  always_comb begin
    in_p     = '0;
    in_p.op  = in_op;
    in_p.tag = in_tag;
    in_p.rs1 = 64'(rs1);
    in_p.rs2 = 64'(rs2);
  end

  assign out_adv = !out_valid || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_in_reg
      sha_payload_t s0;
      logic         s0_v;
      logic         s0_adv;

      assign s0_adv   = !s0_v || out_adv;
      assign in_ready = s0_adv;

      always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
          s0_v <= 1'b0;
          s0   <= '0;
        end else if (flush) begin
          s0_v <= 1'b0;
        end else if (s0_adv) begin
          s0_v <= in_valid;
          if (in_valid) s0 <= in_p;
        end
      end

      assign core_v = s0_v;
      // Idle stage presents zeros so the core does not toggle.
      assign core_p = s0_v ? s0 : '0;
    end else begin : g_no_in_reg
      assign in_ready = out_adv;
      assign core_v   = in_valid;
      assign core_p   = in_valid ? in_p : '0;
    end
  endgenerate

  riscv_crypto_sha_core #(
    .XLEN      (XLEN),
    .SHA512_EN (SHA512_EN)
  ) u_core (
    .op  (core_p.op),
    .rs1 (core_p.rs1[XLEN-1:0]),
    .rs2 (core_p.rs2[XLEN-1:0]),
    .rd  (core_rd),
    .err (core_err)
  );

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= core_v;
      if (core_v) begin
        out_rd  <= core_rd;
        out_tag <= core_p.tag;
        out_err <= core_err;
      end
    end
  end

  assign unused_hi = ^{core_p.rs1, core_p.rs2};

endmodule

// File: tb/tb_riscv_crypto_fu_sha_pipe.sv
// Bench for riscv_crypto_fu_sha_pipe: RV32 single-stage and RV64 two-stage instances.
module tb_riscv_crypto_fu_sha_pipe;

  localparam int W = 70;  // {err, tag[4:0], rd[63:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: XLEN=32, PIPE_STAGES=1 ----------------
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [3:0]  a_in_op = '0;
  logic [4:0]  a_in_tag = '0;
  logic [31:0] a_rs1 = '0, a_rs2 = '0;
  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_rd;
  logic [4:0]  a_out_tag;

  riscv_crypto_fu_sha_pipe #(.XLEN(32), .PIPE_STAGES(1), .SHA512_EN(1)) u_dut32 (
    .g_clk(clk), .g_rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_tag(a_in_tag),
    .rs1(a_rs1), .rs2(a_rs2),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rd(a_out_rd),
    .out_tag(a_out_tag), .out_err(a_out_err)
  );

  // ---------------- DUT B: XLEN=64, PIPE_STAGES=2 ----------------
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [3:0]  b_in_op = '0;
  logic [4:0]  b_in_tag = '0;
  logic [63:0] b_rs1 = '0, b_rs2 = '0;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_rd;
  logic [4:0]  b_out_tag;

  riscv_crypto_fu_sha_pipe #(.XLEN(64), .PIPE_STAGES(2), .SHA512_EN(1)) u_dut64 (
    .g_clk(clk), .g_rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_tag(b_in_tag),
    .rs1(b_rs1), .rs2(b_rs2),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rd(b_out_rd),
    .out_tag(b_out_tag), .out_err(b_out_err)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr32(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0] rr64(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Returns {err, rd[63:0]}; rd is zero above bit 31 for the 32-bit unit.
  function automatic logic [64:0] model(input int xlen, input logic [3:0] op,
                                        input logic [63:0] r1, input logic [63:0] r2);
    logic [31:0] a, b, t;
    logic [63:0] x, y;
    logic        ok;
    a = r1[31:0]; b = r2[31:0]; x = r1; y = '0; t = '0; ok = 1'b1;
    case (op)
      4'd1: t = rr32(a, 7) ^ rr32(a, 18) ^ (a >> 3);
      4'd2: t = rr32(a, 17) ^ rr32(a, 19) ^ (a >> 10);
      4'd3: t = rr32(a, 2) ^ rr32(a, 13) ^ rr32(a, 22);
      4'd4: t = rr32(a, 6) ^ rr32(a, 11) ^ rr32(a, 25);
      4'd5: y = rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7);
      4'd6: y = rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6);
      4'd7: y = rr64(x, 28) ^ rr64(x, 34) ^ rr64(x, 39);
      4'd8: y = rr64(x, 14) ^ rr64(x, 18) ^ rr64(x, 41);
      4'd9:  t = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 25) ^ (b << 24);
      4'd10: t = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 24);
      4'd11: t = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 26) ^ (b << 13);
      4'd12: t = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 13);
      4'd13: t = (a << 25) ^ (a << 30) ^ (a >> 28) ^ (b >> 7) ^ (b >> 2) ^ (b << 4);
      4'd14: t = (a << 23) ^ (a >> 14) ^ (a >> 18) ^ (b >> 9) ^ (b << 18) ^ (b << 14);
      default: ok = 1'b0;
    endcase
    if (op >= 4'd1 && op <= 4'd4) y = {{32{t[31]}}, t};
    if (op >= 4'd9 && op <= 4'd14) y = {32'h0, t};
    if (op >= 4'd5 && op <= 4'd8 && xlen != 64) ok = 1'b0;
    if (op >= 4'd9 && op <= 4'd14 && xlen != 32) ok = 1'b0;
    if (!ok) y = '0;
    if (xlen == 32) y[63:32] = 32'h0;
    return {!ok, y};
  endfunction

  function automatic logic [W-1:0] pack_exp(input logic [64:0] m, input logic [4:0] tag);
    return {m[64], tag, m[63:0]};
  endfunction

  // ---------------- scoreboard monitors (sample at negedge) ----------------
  logic [W-1:0] sb_exp_a, sb_got_a, sb_exp_b, sb_got_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_in_valid && a_in_ready && !a_flush)
        exp_q_a.push_back(pack_exp(model(32, a_in_op, {32'h0, a_rs1}, {32'h0, a_rs2}), a_in_tag));
      if (a_out_valid && a_out_ready && !a_flush) begin
        sb_got_a = {a_out_err, a_out_tag, 32'h0, a_out_rd};
        n_vec++;
        if (exp_q_a.size() == 0) begin
          n_err++;
          $display("FAIL sb_a unexpected result got %h want none", sb_got_a);
        end else begin
          sb_exp_a = exp_q_a.pop_front();
          if (sb_got_a !== sb_exp_a) begin
            n_err++;
            $display("FAIL sb_a result got %h want %h", sb_got_a, sb_exp_a);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_in_valid && b_in_ready && !b_flush)
        exp_q_b.push_back(pack_exp(model(64, b_in_op, b_rs1, b_rs2), b_in_tag));
      if (b_out_valid && b_out_ready && !b_flush) begin
        sb_got_b = {b_out_err, b_out_tag, b_out_rd};
        n_vec++;
        if (exp_q_b.size() == 0) begin
          n_err++;
          $display("FAIL sb_b unexpected result got %h want none", sb_got_b);
        end else begin
          sb_exp_b = exp_q_b.pop_front();
          if (sb_got_b !== sb_exp_b) begin
            n_err++;
            $display("FAIL sb_b result got %h want %h", sb_got_b, sb_exp_b);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] op, input logic [4:0] tag,
                         input logic [31:0] r1, input logic [31:0] r2);
    a_in_valid = v; a_in_op = op; a_in_tag = tag; a_rs1 = r1; a_rs2 = r2;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] op, input logic [4:0] tag,
                         input logic [63:0] r1, input logic [63:0] r2);
    b_in_valid = v; b_in_op = op; b_in_tag = tag; b_rs1 = r1; b_rs2 = r2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({a_out_valid, a_out_rd, a_out_tag, a_out_err} !== 39'h0) begin
      n_err++; $display("FAIL reset_a_outputs got %h want 0", {a_out_valid, a_out_rd, a_out_tag, a_out_err});
    end
    n_vec++;
    if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
    n_vec++;
    if ({b_out_valid, b_out_rd, b_out_tag, b_out_err} !== 71'h0) begin
      n_err++; $display("FAIL reset_b_outputs got %h want 0", {b_out_valid, b_out_rd, b_out_tag, b_out_err});
    end
    n_vec++;
    if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_in_ready got %b want 1", b_in_ready); end
  endtask

  task automatic test_sha256();
    a_out_ready = 1'b1;
    drive_a(1'b1, 4'd1, 5'd3, 32'h0000_0001, 32'h0);
    tick();
    a_in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_out_err, a_out_tag, a_out_rd} !== {1'b1, 1'b0, 5'd3, 32'h0200_4000}) begin
      n_err++; $display("FAIL s256sig0 got v=%b e=%b t=%0d rd=%h want v=1 e=0 t=3 rd=02004000",
                        a_out_valid, a_out_err, a_out_tag, a_out_rd);
    end
    tick();
    n_vec++;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL s256_drained got %b want 0", a_out_valid); end
  endtask

  task automatic test_rv32_sha512();
    a_out_ready = 1'b1;
    drive_a(1'b1, 4'd10, 5'd4, 32'h2, 32'h1);  // SIG0H
    tick();
    drive_a(1'b1, 4'd9, 5'd5, 32'h2, 32'h1);   // SIG0L back-to-back
    n_vec++;
    if ({a_out_tag, a_out_rd} !== {5'd4, 32'h8100_0001}) begin
      n_err++; $display("FAIL sig0h got t=%0d rd=%h want t=4 rd=81000001", a_out_tag, a_out_rd);
    end
    tick();
    drive_a(1'b1, 4'd5, 5'd6, 32'h1, 32'h0);   // S512SIG0 is illegal on RV32
    n_vec++;
    if ({a_out_tag, a_out_rd} !== {5'd5, 32'h8300_0001}) begin
      n_err++; $display("FAIL sig0l got t=%0d rd=%h want t=5 rd=83000001", a_out_tag, a_out_rd);
    end
    tick();
    a_in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_out_err, a_out_rd} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL rv32_illegal got v=%b e=%b rd=%h want v=1 e=1 rd=0", a_out_valid, a_out_err, a_out_rd);
    end
    tick();
  endtask

  task automatic test_xlen64();
    b_out_ready = 1'b1;
    drive_b(1'b1, 4'd5, 5'd7, 64'h1, 64'h0);
    tick();
    drive_b(1'b1, 4'd9, 5'd8, 64'h2, 64'h1);   // SIG0L is illegal on RV64
    tick();
    b_in_valid = 1'b0;
    n_vec++;
    if ({b_out_valid, b_out_err, b_out_tag, b_out_rd} !== {1'b1, 1'b0, 5'd7, 64'h8100_0000_0000_0000}) begin
      n_err++; $display("FAIL s512sig0 got v=%b e=%b t=%0d rd=%h want v=1 e=0 t=7 rd=8100000000000000",
                        b_out_valid, b_out_err, b_out_tag, b_out_rd);
    end
    tick();
    n_vec++;
    if ({b_out_valid, b_out_err, b_out_tag, b_out_rd} !== {1'b1, 1'b1, 5'd8, 64'h0}) begin
      n_err++; $display("FAIL rv64_illegal got v=%b e=%b t=%0d rd=%h want v=1 e=1 t=8 rd=0",
                        b_out_valid, b_out_err, b_out_tag, b_out_rd);
    end
    drive_b(1'b1, 4'd1, 5'd9, 64'h40, 64'h0);  // result bit 31 set: sign-extends
    tick();
    b_in_valid = 1'b0;
    tick();
    n_vec++;
    if (b_out_rd !== 64'hFFFF_FFFF_8010_0008) begin
      n_err++; $display("FAIL s256_sext got %h want ffffffff80100008", b_out_rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] ra;
    logic [64:0] ea;
    ra = {$urandom, $urandom};
    ea = model(64, 4'd2, ra, 64'h0);
    b_out_ready = 1'b0;
    drive_b(1'b1, 4'd2, 5'd10, ra, 64'h0);
    tick();
    drive_b(1'b1, 4'd3, 5'd11, {$urandom, $urandom}, 64'h0);
    tick();
    drive_b(1'b1, 4'd4, 5'd12, {$urandom, $urandom}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", b_in_ready); end
      n_vec++;
      if ({b_out_valid, b_out_tag, b_out_rd} !== {1'b1, 5'd10, ea[63:0]}) begin
        n_err++; $display("FAIL bp_stable got v=%b t=%0d rd=%h want v=1 t=10 rd=%h",
                          b_out_valid, b_out_tag, b_out_rd, ea[63:0]);
      end
      tick();
    end
    b_out_ready = 1'b1;
    #1;
    n_vec++;
    if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    n_vec++;
    if (b_out_tag !== 5'd11) begin n_err++; $display("FAIL bp_drain_tag1 got %0d want 11", b_out_tag); end
    tick();
    n_vec++;
    if (b_out_tag !== 5'd12) begin n_err++; $display("FAIL bp_drain_tag2 got %0d want 12", b_out_tag); end
    tick();
    n_vec++;
    if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", b_out_valid); end
  endtask

  task automatic test_flush();
    b_out_ready = 1'b0;
    drive_b(1'b1, 4'd1, 5'd20, {$urandom, $urandom}, 64'h0);
    tick();
    drive_b(1'b1, 4'd2, 5'd21, {$urandom, $urandom}, 64'h0);
    tick();
    b_flush = 1'b1;
    drive_b(1'b1, 4'd3, 5'd22, {$urandom, $urandom}, 64'h0);
    tick();
    b_flush = 1'b0;
    b_in_valid = 1'b0;
    exp_q_b.delete();
    n_vec++;
    if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_b_out_valid got %b want 0", b_out_valid); end
    b_out_ready = 1'b1;
    tick();
    n_vec++;
    if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_b_leak got %b want 0", b_out_valid); end
    drive_b(1'b1, 4'd4, 5'd23, {$urandom, $urandom}, 64'h0);
    tick();
    b_in_valid = 1'b0;
    tick();
    n_vec++;
    if ({b_out_valid, b_out_tag} !== {1'b1, 5'd23}) begin
      n_err++; $display("FAIL flush_next_op got v=%b t=%0d want v=1 t=23", b_out_valid, b_out_tag);
    end
    tick();
    n_vec++;
    if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_next got %b want 0", b_out_valid); end
    // Input offered alongside flush on the single-stage unit is dropped.
    a_out_ready = 1'b1;
    a_flush = 1'b1;
    drive_a(1'b1, 4'd1, 5'd24, $urandom, 32'h0);
    tick();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    n_vec++;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_a_drop got %b want 0", a_out_valid); end
    tick();
  endtask

  task automatic test_reset_midstream();
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    drive_a(1'b1, 4'd1, 5'd1, $urandom, 32'h0);
    drive_b(1'b1, 4'd1, 5'd2, {$urandom, $urandom}, 64'h0);
    tick();
    a_in_valid = 1'b0;
    drive_b(1'b1, 4'd2, 5'd3, {$urandom, $urandom}, 64'h0);
    tick();
    b_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_a got %b want 0", a_out_valid); end
    n_vec++;
    if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_b got %b want 0", b_out_valid); end
    exp_q_a.delete();
    exp_q_b.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({a_out_valid, b_out_valid} !== 2'b00) begin
        n_err++; $display("FAIL post_rst_idle got a=%b b=%b want 0 0", a_out_valid, b_out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic a_acc, b_acc;
    a_acc = 1'b0;
    b_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(a_in_valid && !a_acc))
        drive_a(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                $urandom, $urandom);
      if (!(b_in_valid && !b_acc))
        drive_b(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                {$urandom, $urandom}, {$urandom, $urandom});
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      a_acc = a_in_valid && a_in_ready;
      b_acc = b_in_valid && b_in_ready;
      tick();
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (exp_q_a.size() != 0) begin n_err++; $display("FAIL drain_a pending got %0d want 0", exp_q_a.size()); end
    n_vec++;
    if (exp_q_b.size() != 0) begin n_err++; $display("FAIL drain_b pending got %0d want 0", exp_q_b.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sha256();
    test_rv32_sha512();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
